// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word reads to a synchronous
// instruction memory and buffers the returned words, each tagged with its
// byte PC, in a small circular FIFO. A redirect flushes the buffer, squashes
// the read in flight and restarts fetching at the target.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int                XLEN     = 32,
    parameter int                IMEM_AW  = 14,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_en,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_inst,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_pc4
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
    localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_reg, pc_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic            inflight_reg, inflight_next;
    logic [XLEN-1:0] inflight_pc_reg, inflight_pc_next;

    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic [CW:0]     occupancy;
    logic            push;
    logic            pop;

    // Slots already committed: buffered words plus the one read still returning.
    assign occupancy = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};

    // Only issue when the returning word is guaranteed a free slot.
    assign imem_en   = ~rst & ~redirect_valid & (occupancy < DEPTH_W);
    assign imem_addr = pc_reg[IMEM_AW+1:2];

    // Returning data is dropped when a redirect squashes it.
    assign push      = inflight_reg & ~redirect_valid;
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid & out_ready;

    // Head fields are forced to zero when empty so reset shows clean outputs.
    assign out_inst  = out_valid ? inst_mem[rd_ptr_reg] : 32'd0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]   : '0;
    assign out_pc4   = out_valid ? (pc_mem[rd_ptr_reg] + PC_STEP) : '0;

    // Next-state for fetch PC, FIFO bookkeeping and the in-flight tag.
    always_comb begin
        pc_next          = pc_reg;
        count_next       = count_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        inflight_next    = imem_en;
        inflight_pc_next = imem_en ? pc_reg : inflight_pc_reg;

        if (redirect_valid) begin
            pc_next     = redirect_pc & ALIGN_MASK;
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (imem_en) begin
                pc_next = pc_reg + PC_STEP;
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            count_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            pc_reg          <= pc_next;
            count_reg       <= count_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
        end
    end

    // Buffer storage: write the returning word with the PC it was fetched at.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM word k holds k, expected PCs are queued
// when stimulus establishes a fetch stream and popped on each handshake.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // 32-bit instance (defaults)
    logic        imem_en;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    // 16-bit instance for PC wrap
    logic        imem_en2;
    logic [13:0] imem_addr2;
    logic [31:0] imem_rdata2 = '0;
    logic        redirect_valid2 = 1'b0;
    logic [15:0] redirect_pc2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [31:0] out_inst2;
    logic [15:0] out_pc2;
    logic [15:0] out_pc42;

    int errors = 0;
    int checks = 0;
    int en_cnt;
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_pc4(out_pc4)
    );

    fetch_unit #(.XLEN(16), .IMEM_AW(14), .DEPTH(4), .RESET_PC(16'hFFFC)) dut16 (
        .clk(clk), .rst(rst),
        .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_inst(out_inst2), .out_pc(out_pc2), .out_pc4(out_pc42)
    );

    // Synchronous ROMs: word k = k, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_en)  imem_rdata  <= {18'd0, imem_addr};
        if (imem_en2) imem_rdata2 <= {18'd0, imem_addr2};
    end

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return {18'd0, pc[15:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_seq32(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) q1.push_back(start + 32'(4 * i));
    endtask

    task automatic push_seq16(input logic [15:0] start, input int n);
        logic [15:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            q2.push_back({16'd0, p});
            p = p + 16'd4;
        end
    endtask

    // Compare any handshake on either instance against the scoreboards.
    task automatic sample_pops(input logic redir, input logic [31:0] rpc);
        logic [31:0] e;
        if (out_valid && out_ready) begin
            chk("pop_expected", {31'd0, (q1.size() != 0)}, 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("out_pc", out_pc, e);
                chk("out_inst", out_inst, exp_inst(e));
                chk("out_pc4", out_pc4, e + 32'd4);
                $display("pop32 pc=%h inst=%h", out_pc, out_inst);
            end
        end
        if (redir) begin
            q1.delete();
            push_seq32({rpc[31:2], 2'b00}, 16);
        end
        if (out_valid2 && out_ready2 && q2.size() != 0) begin
            e = q2.pop_front();
            chk("out_pc16", {16'd0, out_pc2}, e);
            chk("out_inst16", out_inst2, exp_inst(e));
            chk("out_pc4_16", {16'd0, out_pc42}, {16'd0, e[15:0] + 16'd4});
            $display("pop16 pc=%h pc4=%h inst=%h", out_pc2, out_pc42, out_inst2);
        end
    endtask

    task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        if (imem_en) en_cnt++;
        sample_pops(redir, rpc);
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst            = 1'b1;
        out_ready      = rdy;
        redirect_valid = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_pc4", out_pc4, 32'd0);
        chk("rst_out_valid16", {31'd0, out_valid2}, 32'd0);
        q1.delete();
        q2.delete();
        push_seq32(32'd0, 16);
        push_seq16(16'hFFFC, 3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        en_cnt = 0;
        if (imem_en) en_cnt++;
        chk("release_imem_en", {31'd0, imem_en}, 32'd1);
        chk("release_addr", {18'd0, imem_addr}, 32'd0);
        chk("release_addr16", {18'd0, imem_addr2}, 32'h3FFF);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;

        // Reset release with consumer always ready: one word per cycle from cycle 2.
        do_reset(1'b1);
        tick(1'b1, 1'b0, 32'd0);
        chk("first_valid_c1", {31'd0, out_valid}, 32'd0);
        tick(1'b1, 1'b0, 32'd0);
        chk("first_valid_c2", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 32'd0);
            chk("throughput_valid", {31'd0, out_valid}, 32'd1);
        end

        // Reset mid-stream with a read in flight, then stall for 20 cycles.
        chk("inflight_before_rst", {31'd0, imem_en}, 32'd1);
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 32'd0);
        chk("stall_issue_count", 32'(en_cnt), 32'd4);
        chk("stall_imem_en", {31'd0, imem_en}, 32'd0);
        chk("stall_pc", {18'd0, imem_addr}, 32'd4);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_head_pc", out_pc, 32'd0);
        chk("stall_head_inst", out_inst, 32'd0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 32'd0);

        // Redirect while 3 entries buffered and a read in flight.
        tick(1'b0, 1'b1, 32'h300);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'd0);
        chk("pre_redirect_valid", {31'd0, out_valid}, 32'd1);
        tick(1'b0, 1'b1, 32'h103);
        tick(1'b0, 1'b0, 32'd0);
        chk("squash_valid_r1", {31'd0, out_valid}, 32'd0);
        chk("squash_addr_r1", {18'd0, imem_addr}, 32'h40);
        tick(1'b1, 1'b0, 32'd0);
        chk("squash_valid_r2", {31'd0, out_valid}, 32'd0);
        tick(1'b1, 1'b0, 32'd0);
        chk("target_valid_r3", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 32'd0);

        // Redirect coinciding with a pop handshake.
        tick(1'b1, 1'b1, 32'h40);
        chk("pop_at_redirect_valid", {31'd0, out_valid}, 32'd1);
        tick(1'b1, 1'b0, 32'd0);
        chk("post_pop_redirect_r1", {31'd0, out_valid}, 32'd0);
        tick(1'b1, 1'b0, 32'd0);
        tick(1'b1, 1'b0, 32'd0);
        chk("post_pop_redirect_r3", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
